// File: rtl/ws2812_tx_if.sv
// Pixel-fetch / serial-status bundle between the display mapping logic and ws2812_tx.
interface ws2812_tx_if #(
  parameter int unsigned IDX_W = 4
);
  logic             start;
  logic [23:0]      pix_grb;
  logic [IDX_W-1:0] pix_idx;
  logic             dout;
  logic             busy;
  logic             done;

  // Upstream side: requests frames and answers pixel lookups.
  modport master (
    output start,
    output pix_grb,
    input  pix_idx,
    input  dout,
    input  busy,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  start,
    input  pix_grb,
    output pix_idx,
    output dout,
    output busy,
    output done
  );
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 strip transmitter: fetches GRB pixels by index, sends them MSB-first with
// pulse-width NRZ coding, then holds the line low for the latch gap.
module ws2812_tx #(
  parameter int unsigned NUM_LEDS     = 12,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned TBIT         = 62,
  parameter int unsigned T0H          = 20,
  parameter int unsigned T1H          = 40,
  parameter int unsigned RESET_CYCLES = 2600
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  ws2812_tx_if.slave     bus
);

  localparam int unsigned PIX_W   = 24;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned CNT_MAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);
  localparam logic [BIT_W-1:0] MSB_BIT  = BIT_W'(PIX_W - 1);

  // Reject illegal timing / strip-length parameters at elaboration.
  if (NUM_LEDS < 1 || NUM_LEDS > (1 << IDX_W) || T0H == 0 || !(T0H < T1H) || !(T1H < TBIT))
  begin : g_bad_params
    $error("ws2812_tx: need 1<=NUM_LEDS<=2^IDX_W and 0<T0H<T1H<TBIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               last_q, last_d;
  logic               pending_q, pending_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dout_q, dout_d;

  // State and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      pix_idx_q <= '0;
      last_q    <= 1'b0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      pix_idx_q <= pix_idx_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
    end
  end

  // Next-state, bit timing, pixel prefetch and frame sequencing.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    pix_idx_d = pix_idx_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pending_d = pending_q | (bus.start & busy_q);
    // Line is high for the first T0H/T1H cycles of each bit period of the current MSB.
    dout_d    = (state_q == SEND) && (cyc_cnt_q < (shreg_q[PIX_W-1] ? T1H_C : T0H_C));

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = FETCH;
          pix_idx_d = '0;
          busy_d    = 1'b1;
        end
      end

      FETCH: begin
        shreg_d   = bus.pix_grb;
        bit_cnt_d = MSB_BIT;
        cyc_cnt_d = '0;
        last_d    = 1'b0;
        state_d   = SEND;
      end

      SEND: begin
        if (cyc_cnt_q == BIT_END) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == '0) begin
            if (last_q) begin
              // Park the index on pixel 0 so the next frame's lookup has long settled.
              state_d   = GAP;
              pix_idx_d = '0;
            end else begin
              shreg_d   = bus.pix_grb;
              bit_cnt_d = MSB_BIT;
            end
          end else begin
            shreg_d   = {shreg_q[PIX_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            // Last bit of the pixel begins: request the next one a full bit early.
            if (bit_cnt_q == BIT_W'(1)) begin
              if (pix_idx_q == LAST_IDX) begin
                last_d = 1'b1;
              end else begin
                pix_idx_d = pix_idx_q + IDX_W'(1);
              end
            end
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (cyc_cnt_q == GAP_END) begin
          done_d    = 1'b1;
          pending_d = 1'b0;
          if (pending_q || bus.start) begin
            state_d   = FETCH;
            pix_idx_d = '0;
            busy_d    = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.pix_idx = pix_idx_q;
  assign bus.dout    = dout_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: four instances (1, 3, 2 and 12 LEDs) with registered pixel lookups.
module tb_ws2812_tx;

  localparam int TBIT    = 62;
  localparam int T0H     = 20;
  localparam int T1H     = 40;
  localparam int RST_CYC = 2600;
  localparam int NINST   = 4;
  localparam int FRAME12 = 20458;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic        rst_a   [NINST];
  logic        start_a [NINST];
  logic        dout_a  [NINST];
  logic        busy_a  [NINST];
  logic        done_a  [NINST];
  logic [3:0]  idx_a   [NINST];
  logic [23:0] mem     [NINST][16];

  int tests = 0;
  int fails = 0;

  int rise_q [NINST][$];
  int fall_q [NINST][$];
  int done_q [NINST][$];
  int bdone_q[NINST][$];
  int idxc_q [NINST][$];
  int idxv_q [NINST][$];

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int unsigned NL = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 12;
    ws2812_tx_if #(.IDX_W(4)) bus ();
    ws2812_tx #(.NUM_LEDS(NL), .IDX_W(4)) dut (
      .CLOCK_50 (clk),
      .reset    (rst_a[g]),
      .bus      (bus)
    );
    assign bus.start = start_a[g];
    always @(posedge clk) bus.pix_grb <= mem[g][bus.pix_idx];
    assign dout_a[g] = bus.dout;
    assign busy_a[g] = bus.busy;
    assign done_a[g] = bus.done;
    assign idx_a[g]  = bus.pix_idx;
  end

  // Edge log: cycle index of the clock edge that produced each observed change.
  logic       dout_p [NINST];
  logic [3:0] idx_p  [NINST];
  always @(negedge clk) begin
    for (int k = 0; k < NINST; k++) begin
      if (dout_a[k] === 1'b1 && dout_p[k] === 1'b0) rise_q[k].push_back(cycle);
      if (dout_a[k] === 1'b0 && dout_p[k] === 1'b1) fall_q[k].push_back(cycle);
      if (done_a[k] === 1'b1) begin
        done_q[k].push_back(cycle);
        bdone_q[k].push_back(int'(busy_a[k]));
      end
      if (idx_a[k] !== idx_p[k]) begin
        idxc_q[k].push_back(cycle);
        idxv_q[k].push_back(int'(idx_a[k]));
      end
      dout_p[k] = dout_a[k];
      idx_p[k]  = idx_a[k];
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q(input int k);
    rise_q[k].delete();
    fall_q[k].delete();
    done_q[k].delete();
    bdone_q[k].delete();
    idxc_q[k].delete();
    idxv_q[k].delete();
  endtask

  task automatic wait_done(input int k, input int count, input int limit, input string tag);
    for (int n = 0; n < limit && done_q[k].size() < count; n++) tick();
    check({tag, " done pulses seen"}, done_q[k].size(), count);
  endtask

  // Decode npix pixels starting at rise index r0 and compare against mem[k].
  task automatic check_stream(input int k, input int r0, input int npix, input string tag);
    int badw, badp, hi, i;
    logic [23:0] word;
    logic        b;
    logic [23:0] exp_px;
    if (rise_q[k].size() < r0 + npix * 24 || fall_q[k].size() < r0 + npix * 24) begin
      check({tag, " stream complete"}, rise_q[k].size(), r0 + npix * 24);
      return;
    end
    badw = 0;
    badp = 0;
    for (int p = 0; p < npix; p++) begin
      word   = '0;
      exp_px = mem[k][p];
      for (int bi = 0; bi < 24; bi++) begin
        i  = r0 + p * 24 + bi;
        hi = fall_q[k][i] - rise_q[k][i];
        b  = (hi == T1H);
        if (hi != (exp_px[23 - bi] ? T1H : T0H)) badw++;
        if (i > r0 && rise_q[k][i] - rise_q[k][i-1] != TBIT) badp++;
        word = {word[22:0], b};
      end
      check($sformatf("%s pixel %0d", tag, p), word, exp_px);
    end
    check({tag, " high-width errors"}, badw, 0);
    check({tag, " bit-period errors"}, badp, 0);
  endtask

  // One start pulse, full frame decode and timing checks against a hand latency.
  task automatic run_frame(input int k, input int nleds, input int lat, input string tag);
    int s, d, r_last, exp_chg;
    clear_q(k);
    start_a[k] = 1'b1;
    s = cycle + 1;
    tick();
    start_a[k] = 1'b0;
    wait_done(k, 1, lat + 200, tag);
    if (done_q[k].size() < 1) return;
    d = done_q[k][0];
    check({tag, " done latency"}, d - s, lat);
    check({tag, " busy low at done"}, bdone_q[k][0], 0);
    check({tag, " rise count"}, rise_q[k].size(), nleds * 24);
    if (rise_q[k].size() >= nleds * 24) begin
      check({tag, " first rise after sample"}, rise_q[k][0] - s, 2);
      r_last = rise_q[k][nleds*24-1];
      check({tag, " latch gap"}, d - (r_last + TBIT), RST_CYC);
    end
    check_stream(k, 0, nleds, tag);
    exp_chg = (nleds > 1) ? nleds : 0;
    check({tag, " pix_idx changes"}, idxc_q[k].size(), exp_chg);
    for (int p = 0; p < nleds - 1; p++) begin
      if (idxc_q[k].size() > p) begin
        check($sformatf("%s idx%0d edge", tag, p + 1), idxc_q[k][p] - s, 1 + (p * 24 + 23) * TBIT);
        check($sformatf("%s idx%0d value", tag, p + 1), idxv_q[k][p], p + 1);
      end
    end
    tick();
    check({tag, " done one cycle"}, int'(done_a[k]), 0);
    check({tag, " busy after done"}, int'(busy_a[k]), 0);
  endtask

  typedef struct {
    int          k;
    int          nleds;
    logic [23:0] p0;
    logic [23:0] p1;
    logic [23:0] p2;
    int          lat;
    string       tag;
  } row_t;

  task automatic main_tests();
    row_t rows [4];
    int s, tgt, bad;
    rows[0] = '{0, 1, 24'hA50F00, 24'h000000, 24'h000000, 4090, "1led A50F00"};
    rows[1] = '{1, 3, 24'hFFFFFF, 24'h000000, 24'h800001, 7066, "3led prefetch"};
    rows[2] = '{2, 2, 24'h123456, 24'hFEDCBA, 24'h000000, 5578, "2led"};
    rows[3] = '{0, 1, 24'h000001, 24'h000000, 24'h000000, 4090, "1led 000001"};

    for (int r = 0; r < 4; r++) begin
      mem[rows[r].k][0] = rows[r].p0;
      mem[rows[r].k][1] = rows[r].p1;
      mem[rows[r].k][2] = rows[r].p2;
      repeat (3) tick();
      run_frame(rows[r].k, rows[r].nleds, rows[r].lat, rows[r].tag);
    end

    // Three start pulses during SEND collapse into exactly one extra frame.
    clear_q(2);
    start_a[2] = 1'b1;
    s = cycle + 1;
    tick();
    start_a[2] = 1'b0;
    repeat (300) tick();
    repeat (3) begin
      start_a[2] = 1'b1;
      tick();
      start_a[2] = 1'b0;
      repeat (400) tick();
    end
    wait_done(2, 2, 2 * 5578 + 300, "pending");
    if (done_q[2].size() >= 2) begin
      check("pending first done", done_q[2][0] - s, 5578);
      check("pending second done", done_q[2][1] - done_q[2][0], 5578);
      check("pending busy held at done", bdone_q[2][0], 1);
      check("pending busy low at final done", bdone_q[2][1], 0);
      check("pending rise count", rise_q[2].size(), 96);
      if (rise_q[2].size() >= 49)
        check("pending 2nd frame first rise", rise_q[2][48] - done_q[2][0], 2);
      check_stream(2, 0, 2, "pending frame1");
      check_stream(2, 48, 2, "pending frame2");
    end
    repeat (200) tick();
    check("pending no third frame", done_q[2].size(), 2);
    check("pending idle busy", int'(busy_a[2]), 0);

    // Reset during the high phase of pixel 1, bit 10.
    clear_q(2);
    start_a[2] = 1'b1;
    s = cycle + 1;
    tick();
    start_a[2] = 1'b0;
    tgt = s + 2 + 37 * TBIT + 5;
    while (cycle < tgt) tick();
    check("midreset dout high before", int'(dout_a[2]), 1);
    rst_a[2] = 1'b1;
    tick();
    bad = 0;
    if (dout_a[2] !== 1'b0) bad++;
    if (busy_a[2] !== 1'b0) bad++;
    if (done_a[2] !== 1'b0) bad++;
    if (idx_a[2] !== 4'd0) bad++;
    check("midreset outputs cleared", bad, 0);
    repeat (2) tick();
    rst_a[2] = 1'b0;
    repeat (RST_CYC + 10) tick();
    check("midreset still idle", int'(busy_a[2]), 0);
    run_frame(2, 2, 5578, "post-reset");
  endtask

  // start held high on the 12-LED instance: frames back to back.
  task automatic b2b_test();
    int s, nr, base;
    for (int i = 0; i < 12; i++) mem[3][i] = 24'(32'h0F1E2D * (i + 1));
    repeat (3) tick();
    clear_q(3);
    start_a[3] = 1'b1;
    s = cycle + 1;
    wait_done(3, 3, 3 * FRAME12 + 300, "b2b");
    start_a[3] = 1'b0;
    rst_a[3] = 1'b1;
    repeat (2) tick();
    rst_a[3] = 1'b0;
    if (done_q[3].size() < 3) return;
    check("b2b frame0 length", done_q[3][0] - s, FRAME12);
    check("b2b frame1 period", done_q[3][1] - done_q[3][0], FRAME12);
    check("b2b frame2 period", done_q[3][2] - done_q[3][1], FRAME12);
    check("b2b busy held at done0", bdone_q[3][0], 1);
    check("b2b busy held at done1", bdone_q[3][1], 1);
    nr = 0;
    foreach (rise_q[3][i]) if (rise_q[3][i] < done_q[3][2]) nr++;
    check("b2b rise count", nr, 3 * 288);
    if (nr < 3 * 288) return;
    for (int f = 0; f < 3; f++) begin
      base = (f == 0) ? s : done_q[3][f-1];
      check($sformatf("b2b frame%0d first rise", f), rise_q[3][f*288] - base, 2);
      check($sformatf("b2b frame%0d gap", f), done_q[3][f] - (rise_q[3][f*288+287] + TBIT), RST_CYC);
      check_stream(3, f * 288, 12, $sformatf("b2b frame%0d", f));
    end
  endtask

  initial begin
    int bad [NINST];
    for (int k = 0; k < NINST; k++) begin
      rst_a[k]   = 1'b1;
      start_a[k] = 1'b0;
      for (int i = 0; i < 16; i++) mem[k][i] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < NINST; k++) rst_a[k] = 1'b0;

    for (int k = 0; k < NINST; k++) bad[k] = 0;
    repeat (100) begin
      tick();
      for (int k = 0; k < NINST; k++)
        if (dout_a[k] !== 1'b0 || busy_a[k] !== 1'b0 || done_a[k] !== 1'b0 || idx_a[k] !== 4'd0)
          bad[k]++;
    end
    for (int k = 0; k < NINST; k++) check($sformatf("idle after reset inst%0d", k), bad[k], 0);

    fork
      main_tests();
      b2b_test();
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
